// File: rtl/synth_cfg_loader.sv
// synth_cfg_loader: byte-serial configuration loader for the synth core.
//
// Address/data bytes arrive on asynchronous pins and are synchronised into clk.
// Data bytes land in a shadow bank. A commit request copies the whole shadow
// bank to the active bank on the next sequencer frame boundary, so the synth
// datapath never sees a half-updated parameter set inside a frame.
//
// Optional feature: define SYNTH_CFG_READBACK_EN to build a registered
// readback port (rd_data = shadow[addr], or 0 when addr is out of range).
// Without the macro rd_data is tied to 0 and no readback logic is built.

module synth_cfg_loader #(
    parameter int unsigned NUM_BYTES = 10,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             pin_data,
    input  logic                   pin_strobe,
    input  logic                   pin_is_addr,
    input  logic                   pin_commit,
    input  logic                   frame_start,
    output logic [8*NUM_BYTES-1:0] cfg,
    output logic                   commit_pending,
    output logic                   commit_done,
    output logic [7:0]             rd_data
);

    typedef enum logic [0:0] {
        StIdle,
        StPending
    } state_e;

    // Synchroniser stages (s1, s2) and edge-detect stage (s3).
    logic [7:0] data_s1_q, data_s2_q;
    logic       is_addr_s1_q, is_addr_s2_q;
    logic       strobe_s1_q, strobe_s2_q, strobe_s3_q;
    logic       commit_s1_q, commit_s2_q, commit_s3_q;

    // Counts the cycles since reset release until the synchroniser holds real
    // pin values; edges are ignored until then so a pin held high across
    // reset does not look like a fresh rising edge.
    logic [1:0] fill_q;
    logic       sync_ready;

    logic       strobe_evt;
    logic       commit_evt;

    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           shadow_q [NUM_BYTES];
    logic [7:0]           shadow_d [NUM_BYTES];
    logic [7:0]           active_q [NUM_BYTES];
    logic [7:0]           active_d [NUM_BYTES];

    state_e state_q, state_d;
    logic   copy;
    logic   done_q;

    // Pin synchronisers, edge flops and fill counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_s1_q    <= 8'h00;
            data_s2_q    <= 8'h00;
            is_addr_s1_q <= 1'b0;
            is_addr_s2_q <= 1'b0;
            strobe_s1_q  <= 1'b0;
            strobe_s2_q  <= 1'b0;
            strobe_s3_q  <= 1'b0;
            commit_s1_q  <= 1'b0;
            commit_s2_q  <= 1'b0;
            commit_s3_q  <= 1'b0;
            fill_q       <= 2'd0;
        end else begin
            data_s1_q    <= pin_data;
            data_s2_q    <= data_s1_q;
            is_addr_s1_q <= pin_is_addr;
            is_addr_s2_q <= is_addr_s1_q;
            strobe_s1_q  <= pin_strobe;
            strobe_s2_q  <= strobe_s1_q;
            strobe_s3_q  <= strobe_s2_q;
            commit_s1_q  <= pin_commit;
            commit_s2_q  <= commit_s1_q;
            commit_s3_q  <= commit_s2_q;
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    // Rising-edge events on the synchronised strobe and commit pins.
    always_comb begin
        sync_ready = (fill_q == 2'd3);
        strobe_evt = sync_ready && strobe_s2_q && !strobe_s3_q;
        commit_evt = sync_ready && commit_s2_q && !commit_s3_q;
    end

    // Address pointer and shadow bank next state; out-of-range writes match
    // no entry and are dropped, but the pointer still advances.
    always_comb begin
        addr_d   = addr_q;
        shadow_d = shadow_q;
        if (strobe_evt) begin
            if (is_addr_s2_q) begin
                addr_d = ADDR_BITS'(data_s2_q);
            end else begin
                for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                    if (addr_q == ADDR_BITS'(i)) begin
                        shadow_d[i] = data_s2_q;
                    end
                end
                addr_d = addr_q + ADDR_BITS'(1);
            end
        end
    end

    // Commit FSM: next state and the frame-aligned copy strobe.
    always_comb begin
        state_d = state_q;
        copy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (commit_evt) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                // Commit events seen here are absorbed into this copy.
                if (frame_start) begin
                    copy    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Active bank next state; the copy takes the pre-write shadow contents.
    always_comb begin
        active_d = active_q;
        if (copy) begin
            active_d = shadow_q;
        end
    end

    // Address, banks, FSM state and commit_done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            state_q <= StIdle;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                shadow_q[i] <= 8'h00;
                active_q[i] <= 8'h00;
            end
        end else begin
            addr_q   <= addr_d;
            state_q  <= state_d;
            done_q   <= copy;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Flatten the active bank onto the cfg bus, byte k at [8k+7:8k].
    always_comb begin
        cfg = '0;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            cfg[8*i +: 8] = active_q[i];
        end
    end

    assign commit_pending = (state_q == StPending);
    assign commit_done    = done_q;

`ifdef SYNTH_CFG_READBACK_EN
    logic [7:0] rd_d, rd_q;

    // Readback mux looks at next-state values so rd_data tracks a write or
    // address change one cycle after its event cycle.
    always_comb begin
        rd_d = 8'h00;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (addr_d == ADDR_BITS'(i)) begin
                rd_d = shadow_d[i];
            end
        end
    end

    // Readback register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= 8'h00;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_data = rd_q;
`else
    assign rd_data = 8'h00;
`endif

endmodule

// File: tb/tb_synth_cfg_loader.sv
// Self-checking bench for synth_cfg_loader: vector table, hand-written
// corner-case sequences and a randomized phase against a bank-level model.

module tb_synth_cfg_loader;

    localparam int NB = 10;

    localparam int OP_ADDR   = 0;
    localparam int OP_DATA   = 1;
    localparam int OP_COMMIT = 2;
    localparam int OP_FRAME  = 3;

    typedef struct {
        int         op;
        logic [7:0] val;
        int         chk_idx;
        logic [7:0] chk_val;
        logic       chk_pend;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      pin_data;
    logic            pin_strobe;
    logic            pin_is_addr;
    logic            pin_commit;
    logic            frame_start;
    logic [8*NB-1:0] cfg;
    logic            commit_pending;
    logic            commit_done;
    logic [7:0]      rd_data;

    always #5 clk = ~clk;

    synth_cfg_loader #(
        .NUM_BYTES(NB),
        .ADDR_BITS(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pin_data      (pin_data),
        .pin_strobe    (pin_strobe),
        .pin_is_addr   (pin_is_addr),
        .pin_commit    (pin_commit),
        .frame_start   (frame_start),
        .cfg           (cfg),
        .commit_pending(commit_pending),
        .commit_done   (commit_done),
        .rd_data       (rd_data)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int done_count = 0;
    int exp_done = 0;

    // Reference model: two byte banks, a pointer and a pending flag.
    logic [7:0] m_shadow [NB];
    logic [7:0] m_active [NB];
    int         m_addr;
    bit         m_pend;

    vec_t vecs[$];

    always @(negedge clk) begin
        if (commit_done === 1'b1) done_count++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [8*NB-1:0] got,
                       input logic [8*NB-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NB; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = 8'h00;
        end
        m_addr = 0;
        m_pend = 1'b0;
    endfunction

    function automatic void m_strobe(input bit is_addr, input logic [7:0] val);
        if (is_addr) begin
            m_addr = int'(val);
        end else begin
            if (m_addr < NB) m_shadow[m_addr] = val;
            m_addr = (m_addr + 1) % 256;
        end
    endfunction

    function automatic void m_frame();
        if (m_pend) begin
            for (int i = 0; i < NB; i++) m_active[i] = m_shadow[i];
            m_pend = 1'b0;
            exp_done++;
        end
    endfunction

    function automatic logic [8*NB-1:0] m_cfg();
        logic [8*NB-1:0] r;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = m_active[i];
        return r;
    endfunction

    function automatic logic [7:0] m_rd();
`ifdef SYNTH_CFG_READBACK_EN
        if (m_addr < NB) return m_shadow[m_addr];
        return 8'h00;
`else
        return 8'h00;
`endif
    endfunction

    task automatic full_check(input string tag);
        chk({tag, "/cfg"}, cfg, m_cfg());
        chk({tag, "/pending"}, commit_pending, m_pend);
        chk({tag, "/done_count"}, done_count, exp_done);
        chk({tag, "/rd_data"}, rd_data, m_rd());
    endtask

    task automatic do_strobe(input bit is_addr, input logic [7:0] val);
        pin_data    = val;
        pin_is_addr = is_addr;
        tick(3);
        pin_strobe = 1'b1;
        tick(4);
        pin_strobe = 1'b0;
        tick(4);
        m_strobe(is_addr, val);
    endtask

    task automatic do_commit();
        pin_commit = 1'b1;
        tick(4);
        pin_commit = 1'b0;
        tick(4);
        m_pend = 1'b1;
    endtask

    task automatic do_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(2);
        m_frame();
    endtask

    task automatic do_op(input int op, input logic [7:0] val);
        case (op)
            OP_ADDR:   do_strobe(1'b1, val);
            OP_DATA:   do_strobe(1'b0, val);
            OP_COMMIT: do_commit();
            default:   do_frame();
        endcase
    endtask

    // Commit rising edge whose event cycle coincides with a frame_start.
    task automatic commit_with_frame();
        pin_commit = 1'b1;
        tick(2);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(3);
        pin_commit = 1'b0;
        tick(4);
    endtask

    initial begin
        reset       = 1'b1;
        pin_data    = 8'h00;
        pin_strobe  = 1'b0;
        pin_is_addr = 1'b0;
        pin_commit  = 1'b0;
        frame_start = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(4);
        m_reset();
        full_check("reset");

        // Vector table: op, value, cfg byte to check, its value, pending.
        vecs.push_back('{OP_ADDR,   8'h00, 0, 8'h00, 1'b0});
        vecs.push_back('{OP_DATA,   8'hA5, 0, 8'h00, 1'b0});
        vecs.push_back('{OP_DATA,   8'h3C, 1, 8'h00, 1'b0});
        vecs.push_back('{OP_COMMIT, 8'h00, 0, 8'h00, 1'b1});
        vecs.push_back('{OP_FRAME,  8'h00, 0, 8'hA5, 1'b0});
        vecs.push_back('{OP_FRAME,  8'h00, 1, 8'h3C, 1'b0});
        vecs.push_back('{OP_ADDR,   8'h09, 9, 8'h00, 1'b0});
        vecs.push_back('{OP_DATA,   8'h11, 9, 8'h00, 1'b0});
        vecs.push_back('{OP_DATA,   8'h22, 9, 8'h00, 1'b0});
        vecs.push_back('{OP_DATA,   8'h33, 9, 8'h00, 1'b0});
        vecs.push_back('{OP_COMMIT, 8'h00, 9, 8'h00, 1'b1});
        vecs.push_back('{OP_FRAME,  8'h00, 9, 8'h11, 1'b0});
        vecs.push_back('{OP_ADDR,   8'h09, 0, 8'hA5, 1'b0});
        vecs.push_back('{OP_ADDR,   8'h02, 2, 8'h00, 1'b0});
        vecs.push_back('{OP_DATA,   8'h55, 2, 8'h00, 1'b0});
        for (int i = 0; i < 5; i++) vecs.push_back('{OP_FRAME, 8'h00, 2, 8'h00, 1'b0});
        vecs.push_back('{OP_COMMIT, 8'h00, 2, 8'h00, 1'b1});
        vecs.push_back('{OP_FRAME,  8'h00, 2, 8'h55, 1'b0});
        vecs.push_back('{OP_FRAME,  8'h00, 2, 8'h55, 1'b0});

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].val);
            chk($sformatf("tbl%0d/byte%0d", i, vecs[i].chk_idx),
                cfg[8*vecs[i].chk_idx +: 8], vecs[i].chk_val);
            chk($sformatf("tbl%0d/pending", i), commit_pending, vecs[i].chk_pend);
            full_check($sformatf("tbl%0d", i));
        end

        // Data write landing in the same cycle as the copying frame_start.
        do_strobe(1'b1, 8'h04);
        do_commit();
        pin_data    = 8'h7F;
        pin_is_addr = 1'b0;
        tick(3);
        pin_strobe = 1'b1;
        tick(2);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        m_frame();
        m_strobe(1'b0, 8'h7F);
        tick(2);
        pin_strobe = 1'b0;
        tick(4);
        chk("simul_wr/byte4_old", cfg[39:32], 8'h00);
        full_check("simul_wr");
        do_commit();
        do_frame();
        chk("simul_wr/byte4_new", cfg[39:32], 8'h7F);
        full_check("simul_wr2");

        // Commit event together with frame_start while idle: no copy yet.
        do_strobe(1'b0, 8'h66);
        commit_with_frame();
        m_pend = 1'b1;
        chk("commit_idle_frame/pending", commit_pending, 1'b1);
        full_check("commit_idle_frame");
        do_frame();
        full_check("commit_idle_frame2");

        // Commit event together with frame_start while pending: absorbed.
        do_commit();
        do_strobe(1'b0, 8'h77);
        commit_with_frame();
        m_frame();
        chk("commit_pend_frame/pending", commit_pending, 1'b0);
        full_check("commit_pend_frame");

        // Three commits while pending give one copy.
        do_strobe(1'b1, 8'h03);
        do_strobe(1'b0, 8'hC3);
        do_commit();
        do_commit();
        do_commit();
        full_check("triple_commit");
        do_frame();
        do_frame();
        full_check("triple_commit2");

        // Reset while pending with the strobe held high across release.
        do_commit();
        pin_data    = 8'hEE;
        pin_is_addr = 1'b0;
        tick(3);
        pin_strobe = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        m_reset();
        tick(1);
        full_check("reset_mid");
        tick(8);
        full_check("reset_mid2");
        do_commit();
        do_frame();
        chk("reset_mid/no_write", cfg, '0);
        full_check("reset_mid3");
        pin_strobe = 1'b0;
        tick(4);
        do_strobe(1'b1, 8'h00);
        do_strobe(1'b0, 8'h5A);
        do_commit();
        do_frame();
        chk("reset_mid/fresh_write", cfg[7:0], 8'h5A);
        full_check("reset_mid4");

        // Randomized operation mix against the model.
        for (int k = 0; k < 60; k++) begin
            int         r;
            logic [7:0] v;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                if ($urandom_range(0, 3) == 0) v = 8'hFF;
                else v = 8'($urandom_range(0, 13));
                do_op(OP_ADDR, v);
            end else if (r < 6) begin
                v = 8'($urandom_range(0, 255));
                do_op(OP_DATA, v);
            end else if (r < 8) begin
                do_op(OP_COMMIT, 8'h00);
            end else begin
                do_op(OP_FRAME, 8'h00);
            end
            full_check($sformatf("rand%0d", k));
        end
        do_commit();
        do_frame();
        full_check("rand_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
